// File: rtl/ln4017_pkg.sv
// Shared types and helpers for the decade-counter receiver.
// Pure package: no logic, no latency, no flow control.
package ln4017_pkg;

    localparam int DECADE = 10;
    localparam int IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic             legal;
        logic [IDX_W-1:0] idx;
    } code_info_t;

    function automatic code_info_t onehot_idx(input logic [DECADE-1:0] code);
        code_info_t r;
        int         ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < DECADE; i++) begin
            if (code[i]) begin
                r.idx = IDX_W'(i);
                ones++;
            end
        end
        r.legal = (ones == 1);
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] succ(input logic [IDX_W-1:0] v);
        return (v >= IDX_W'(DECADE - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/ln_stable_filter.sv
// Glitch filter: accepts a bus value once it has been sampled STABLE_CYC times in a row.
// Latency: accept is combinational on the STABLE_CYC-th sampling edge; state updates on cp.
// Backpressure: none; en=0 freezes sampling and clears the run counter.
module ln_stable_filter #(
    parameter int W          = 10,
    parameter int STABLE_CYC = 2
) (
    input  logic         cp,
    input  logic         mr_n,
    input  logic         en,
    input  logic [W-1:0] s_in,
    output logic         accept,
    output logic [W-1:0] code
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC - 1);
    localparam logic [3:0] CNT_ACC = (STABLE_CYC >= 2) ? 4'(STABLE_CYC - 2) : 4'd0;

    logic [W-1:0] s_prev;
    logic [W-1:0] last_acc;
    logic [3:0]   cnt;
    logic         same;
    logic         ripe;

    assign same = (s_in == s_prev);
    // With a one-sample window every new value is ripe on its first sample.
    assign ripe   = (STABLE_CYC == 1) ? 1'b1 : (same && (cnt == CNT_ACC));
    assign accept = en && ripe && (s_in != last_acc);
    assign code   = s_in;

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            s_prev   <= '0;
            last_acc <= '0;
            cnt      <= '0;
        end else if (en) begin
            s_prev <= s_in;
            if (!same)
                cnt <= '0;
            else if (cnt < CNT_MAX)
                cnt <= cnt + 1'b1;
            if (accept)
                last_acc <= s_in;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/ln4017_rx.sv
// Decade-bus receiver: filters the one-hot bus, encodes to BCD, checks successor order, counts wraps.
// Latency: outputs registered one edge after the accepting sample (+2 edges with LN4017_RX_SYNC_EN).
// Backpressure: none; en=0 ignores the bus.
module ln4017_rx
    import ln4017_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int WRAP_W     = 8
) (
    input  logic              cp,
    input  logic              mr_n,
    input  logic              en,
    input  logic [DECADE-1:0] d_in,
    output logic [IDX_W-1:0]  bcd_q,
    output logic              valid,
    output logic              q59,
    output logic              carry,
    output logic              err_code,
    output logic              err_seq,
    output logic [WRAP_W-1:0] wrap_cnt
);

    logic [DECADE-1:0] s_in;
    logic [DECADE-1:0] code;
    logic              acc;
    code_info_t        ci;
    state_t            state;

`ifdef LN4017_RX_SYNC_EN
    logic [DECADE-1:0] sync1;
    logic [DECADE-1:0] sync2;

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= d_in;
            sync2 <= sync1;
        end
    end

    assign s_in = sync2;
`else
    assign s_in = d_in;
`endif

    ln_stable_filter #(
        .W          (DECADE),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .cp     (cp),
        .mr_n   (mr_n),
        .en     (en),
        .s_in   (s_in),
        .accept (acc),
        .code   (code)
    );

    assign ci = onehot_idx(code);

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            state    <= IDLE;
            bcd_q    <= '0;
            valid    <= 1'b0;
            q59      <= 1'b0;
            carry    <= 1'b0;
            err_code <= 1'b0;
            err_seq  <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            carry    <= 1'b0;
            err_code <= 1'b0;
            err_seq  <= 1'b0;
            if (acc) begin
                case (state)
                    IDLE, FAULT: begin
                        if (ci.legal) begin
                            // Fresh lock or resync: take the code as-is, no order check.
                            state <= TRACK;
                            bcd_q <= ci.idx;
                            valid <= 1'b1;
                            q59   <= (ci.idx >= IDX_W'(5));
                        end else begin
                            state    <= FAULT;
                            err_code <= 1'b1;
                            valid    <= 1'b0;
                            q59      <= 1'b0;
                        end
                    end
                    TRACK: begin
                        if (!ci.legal) begin
                            state    <= FAULT;
                            err_code <= 1'b1;
                            valid    <= 1'b0;
                            q59      <= 1'b0;
                        end else if (ci.idx == succ(bcd_q)) begin
                            bcd_q <= ci.idx;
                            q59   <= (ci.idx >= IDX_W'(5));
                            if (bcd_q == IDX_W'(DECADE - 1)) begin
                                carry    <= 1'b1;
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end else begin
                            state   <= FAULT;
                            err_seq <= 1'b1;
                            valid   <= 1'b0;
                            q59     <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        valid <= 1'b0;
                        q59   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ln4017_rx.sv
// Bench for ln4017_rx: per-cycle reference model feeds an expected-output queue,
// a monitor pops and compares after each edge; scenario tasks add targeted checks.
module tb_ln4017_rx;

    localparam int SC = 2;

    logic       cp   = 1'b0;
    logic       mr_n = 1'b1;
    logic       en   = 1'b0;
    logic [9:0] d_in = '0;
    logic [3:0] bcd_q;
    logic       valid, q59, carry, err_code, err_seq;
    logic [7:0] wrap_cnt;

    ln4017_rx #(.STABLE_CYC(SC), .WRAP_W(8)) dut (
        .cp       (cp),
        .mr_n     (mr_n),
        .en       (en),
        .d_in     (d_in),
        .bcd_q    (bcd_q),
        .valid    (valid),
        .q59      (q59),
        .carry    (carry),
        .err_code (err_code),
        .err_seq  (err_seq),
        .wrap_cnt (wrap_cnt)
    );

    always #5 cp = ~cp;

    typedef struct packed {
        logic [3:0] bcd;
        logic       valid;
        logic       q59;
        logic       carry;
        logic       err_code;
        logic       err_seq;
        logic [7:0] wrap;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_carry  = 0;
    int   n_errc   = 0;
    int   n_errs   = 0;

    // Reference model state
    logic [9:0] m_prev;
    logic [9:0] m_last;
    int         m_cnt;
    int         m_state;   // 0 idle, 1 track, 2 fault
    int         m_bcd;
    int         m_wrap;

    task automatic model_reset();
        m_prev  = '0;
        m_last  = '0;
        m_cnt   = 0;
        m_state = 0;
        m_bcd   = 0;
        m_wrap  = 0;
    endtask

    // One clock: drive at negedge, predict the post-edge outputs, return 2 ns after the edge.
    task automatic step(input logic e, input logic [9:0] d);
        obs_t x;
        logic acc;
        int   ones, pos;
        @(negedge cp);
        en   = e;
        d_in = d;
        acc  = e && (d == m_prev) && (m_cnt == SC - 2) && (d != m_last);
        if (e) begin
            m_cnt  = (d == m_prev) ? ((m_cnt + 1 > SC - 1) ? SC - 1 : m_cnt + 1) : 0;
            m_prev = d;
        end else begin
            m_cnt = 0;
        end
        x = '0;
        if (acc) begin
            m_last = d;
            ones = 0;
            pos  = 0;
            for (int i = 0; i < 10; i++)
                if (d[i]) begin
                    ones++;
                    pos = i;
                end
            if (ones != 1) begin
                x.err_code = 1'b1;
                m_state    = 2;
            end else if (m_state != 1) begin
                m_state = 1;
                m_bcd   = pos;
            end else if (pos == (m_bcd + 1) % 10) begin
                if (m_bcd == 9) begin
                    x.carry = 1'b1;
                    m_wrap  = (m_wrap + 1) % 256;
                end
                m_bcd = pos;
            end else begin
                x.err_seq = 1'b1;
                m_state   = 2;
            end
        end
        x.bcd   = 4'(m_bcd);
        x.valid = (m_state == 1);
        x.q59   = (m_state == 1) && (m_bcd >= 5);
        x.wrap  = 8'(m_wrap);
        exp_q.push_back(x);
        @(posedge cp);
        #2;
        if (carry)    n_carry++;
        if (err_code) n_errc++;
        if (err_seq)  n_errs++;
    endtask

    task automatic hold(input logic [9:0] d, input int n);
        for (int k = 0; k < n; k++) step(1'b1, d);
    endtask

    function automatic logic [9:0] hot(input int v);
        logic [9:0] one;
        one = 10'b1;
        return one << (v % 10);
    endfunction

    // Scoreboard monitor
    initial begin
        obs_t e, g;
        forever begin
            @(posedge cp);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bcd_q, valid, q59, carry, err_code, err_seq, wrap_cnt};
                n_checks++;
                if (g !== e)
                    $display("FAIL scoreboard t=%0t got bcd=%0d v=%b q59=%b c=%b ec=%b es=%b w=%0d exp bcd=%0d v=%b q59=%b c=%b ec=%b es=%b w=%0d",
                             $time, g.bcd, g.valid, g.q59, g.carry, g.err_code, g.err_seq, g.wrap,
                             e.bcd, e.valid, e.q59, e.carry, e.err_code, e.err_seq, e.wrap);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        #2 mr_n = 1'b0;
        repeat (3) @(posedge cp);
        #1;
        n_checks++;
        if ({bcd_q, valid, q59, carry, err_code, err_seq, wrap_cnt} !== 17'b0)
            $display("FAIL reset_state got %h required 0", {bcd_q, valid, q59, carry, err_code, err_seq, wrap_cnt});
        else n_pass++;
        @(negedge cp);
        mr_n = 1'b1;
        model_reset();
        hold(10'h000, 2);
        n_checks++;
        if (valid !== 1'b0 || err_code !== 1'b0)
            $display("FAIL zero_bus_no_event got valid=%b err_code=%b required 0 0", valid, err_code);
        else n_pass++;
    endtask

    task automatic test_first_code();
        n_errc = 0; n_errs = 0; n_carry = 0;
        step(1'b1, 10'h001);
        n_checks++;
        if (valid !== 1'b0)
            $display("FAIL first_code_early got valid=%b required 0", valid);
        else n_pass++;
        step(1'b1, 10'h001);
        n_checks++;
        if (valid !== 1'b1 || bcd_q !== 4'd0 || (n_errc + n_errs + n_carry) != 0)
            $display("FAIL first_code got valid=%b bcd=%0d pulses=%0d required 1 0 0", valid, bcd_q, n_errc + n_errs + n_carry);
        else n_pass++;
    endtask

    task automatic test_full_count();
        n_carry = 0;
        for (int v = 1; v <= 10; v++) begin
            hold(hot(v), 3);
            n_checks++;
            if (bcd_q !== 4'(v % 10) || q59 !== ((v % 10) >= 5))
                $display("FAIL full_count v=%0d got bcd=%0d q59=%b required %0d %b", v, bcd_q, q59, v % 10, (v % 10) >= 5);
            else n_pass++;
        end
        n_checks++;
        if (n_carry != 1 || wrap_cnt !== 8'd1)
            $display("FAIL full_count_wrap got carries=%0d wrap=%0d required 1 1", n_carry, wrap_cnt);
        else n_pass++;
    endtask

    task automatic test_glitch();
        hold(10'h002, 3);
        hold(10'h004, 3);
        hold(10'h008, 3);
        n_errc = 0; n_errs = 0;
        step(1'b1, 10'h040);
        hold(10'h008, 3);
        n_checks++;
        if (bcd_q !== 4'd3 || valid !== 1'b1 || (n_errc + n_errs) != 0)
            $display("FAIL glitch got bcd=%0d valid=%b errs=%0d required 3 1 0", bcd_q, valid, n_errc + n_errs);
        else n_pass++;
    endtask

    task automatic test_skip();
        step(1'b1, 10'h020);
        step(1'b1, 10'h020);
        n_checks++;
        if (err_seq !== 1'b1 || valid !== 1'b0 || bcd_q !== 4'd3)
            $display("FAIL skip got err_seq=%b valid=%b bcd=%0d required 1 0 3", err_seq, valid, bcd_q);
        else n_pass++;
        step(1'b1, 10'h020);
        n_carry = 0;
        hold(10'h040, 3);
        n_checks++;
        if (valid !== 1'b1 || bcd_q !== 4'd6 || n_carry != 0)
            $display("FAIL resync got valid=%b bcd=%0d carries=%0d required 1 6 0", valid, bcd_q, n_carry);
        else n_pass++;
    endtask

    task automatic test_illegal();
        n_errc = 0;
        hold(10'h003, 3);
        n_checks++;
        if (valid !== 1'b0 || n_errc != 1)
            $display("FAIL illegal_multi got valid=%b err_code pulses=%0d required 0 1", valid, n_errc);
        else n_pass++;
        hold(10'h000, 3);
        n_checks++;
        if (valid !== 1'b0 || n_errc != 2)
            $display("FAIL illegal_zero got valid=%b err_code pulses=%0d required 0 2", valid, n_errc);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        hold(10'h001, 3);
        for (int v = 1; v <= 17; v++) hold(hot(v), 3);
        n_checks++;
        if (bcd_q !== 4'd7 || wrap_cnt !== 8'd2)
            $display("FAIL pre_reset got bcd=%0d wrap=%0d required 7 2", bcd_q, wrap_cnt);
        else n_pass++;
        #1 mr_n = 1'b0;
        #1;
        n_checks++;
        if ({bcd_q, valid, q59, carry, err_code, err_seq, wrap_cnt} !== 17'b0)
            $display("FAIL async_reset got %h required 0", {bcd_q, valid, q59, carry, err_code, err_seq, wrap_cnt});
        else n_pass++;
        mr_n = 1'b1;
        model_reset();
        n_errc = 0; n_errs = 0;
        step(1'b1, 10'h080);
        n_checks++;
        if (valid !== 1'b0)
            $display("FAIL reaccept_early got valid=%b required 0", valid);
        else n_pass++;
        step(1'b1, 10'h080);
        n_checks++;
        if (valid !== 1'b1 || bcd_q !== 4'd7 || (n_errc + n_errs) != 0)
            $display("FAIL reaccept got valid=%b bcd=%0d errs=%0d required 1 7 0", valid, bcd_q, n_errc + n_errs);
        else n_pass++;
    endtask

    task automatic test_enable();
        for (int k = 0; k < 3; k++) step(1'b0, 10'h100);
        n_checks++;
        if (bcd_q !== 4'd7 || valid !== 1'b1)
            $display("FAIL enable_off got bcd=%0d valid=%b required 7 1", bcd_q, valid);
        else n_pass++;
        hold(10'h100, 2);
        n_checks++;
        if (bcd_q !== 4'd8 || q59 !== 1'b1)
            $display("FAIL enable_on got bcd=%0d q59=%b required 8 1", bcd_q, q59);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_code();
        test_full_count();
        test_glitch();
        test_skip();
        test_illegal();
        test_async_reset();
        test_enable();
        repeat (2) @(posedge cp);
        #3;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ln4017_rx.md
Name: ln4017_rx

Overview:
- Receiving end of the decade-counter interface: samples the 10-line one-hot bus a decade counter drives, filters glitches, and encodes the active line to BCD.
- Checks that every step is the successor (mod 10) of the previous one, flags illegal codes and skipped or backward steps, and counts 9->0 wraps.
- Sits downstream of a decade counter driving step lines, for sequence monitoring and readback.

Parameters:
- STABLE_CYC, 2, consecutive identical samples required before a code is accepted; legal range 1..15.
- WRAP_W, 8, width of the wrap counter.

Ports:
- cp  input  1  clock; all state updates on the rising edge.
- mr_n  input  1  master reset; asynchronous, active-low.
- en  input  1  sample enable; 0 = bus ignored.
- d_in  input  10  one-hot decade bus; bit i = count i.
- bcd_q  output  4  index of the last accepted legal code, 0..9.
- valid  output  1  bcd_q tracks the bus (state TRACK).
- q59  output  1  valid & (bcd_q >= 5).
- carry  output  1  one-cycle pulse on an accepted 9->0 step.
- err_code  output  1  one-cycle pulse on an accepted illegal code (zero or multi-hot).
- err_seq  output  1  one-cycle pulse on an accepted legal non-successor code.
- wrap_cnt  output  WRAP_W  count of carry pulses; wraps modulo 2^WRAP_W.

Behaviour:
- Reset (mr_n=0, async): state IDLE, bcd_q=0, valid=0, q59=0, carry=0, err_code=0, err_seq=0, wrap_cnt=0, last_acc=10'b0, stability counter=0, s_prev=0. Reset overrides any same-edge event.
- Filter:
  - s_in is d_in, or the synchronised d_in when the optional feature is enabled.
  - Each edge with en=1: if s_in==s_prev, cnt saturates at STABLE_CYC-1; otherwise cnt=0. s_prev<=s_in.
  - en=0: cnt=0; no events.
  - Accept event when en=1, s_in==s_prev, cnt==STABLE_CYC-2 (or STABLE_CYC==1), and s_in!=last_acc. last_acc<=s_in.
  - A code therefore takes effect on the edge that samples it for the STABLE_CYC-th consecutive time. Shorter glitches are dropped.
- Legal code: exactly one bit set, idx = position of that bit. Anything else is illegal.
- State machine (IDLE, TRACK, FAULT), acting on accept events only:
  - IDLE, legal: ->TRACK, bcd_q=idx. No sequence check, no carry.
  - IDLE, illegal: err_code pulse, ->FAULT.
  - TRACK, legal with idx==(bcd_q+1) mod 10: bcd_q=idx. If bcd_q was 9: carry pulse, wrap_cnt+1.
  - TRACK, legal non-successor: err_seq pulse, ->FAULT, bcd_q holds.
  - TRACK, illegal: err_code pulse, ->FAULT.
  - FAULT, legal: ->TRACK, bcd_q=idx (resync, no carry, no err).
  - FAULT, illegal: err_code pulse, stay.
- valid = (state==TRACK). All outputs are registered. Pulses are high for exactly one cycle. Accepted events can occur in back-to-back cycles only when STABLE_CYC==1.
- The all-zero bus after reset is not an event, because last_acc starts at 0.

Optional Feature:
- Macro: LN4017_RX_SYNC_EN.
- Defined: d_in passes through a 2-flop synchroniser (reset 0) before the filter; latency +2 cycles.
- Undefined: d_in feeds the filter directly; d_in must be synchronous to cp.

Decomposition:
- Package ln4017_pkg:
  - DECADE=10, IDX_W=4.
  - State enum {IDLE, TRACK, FAULT}.
  - Function onehot_idx (returns idx plus a legal flag).
  - Function succ (mod-10 increment).
- One sub-module, ln_stable_filter: the s_prev/cnt/last_acc logic, parameterised on width and STABLE_CYC, emitting accept and code.

Test Plan:
- Reset/first code: reset, then d_in=10'h001 held 2 cycles -> bcd_q=0, valid=1 after the 2nd edge; no pulses.
- Full count: step 0..9 then 0, each held 3 cycles -> bcd_q follows; q59=1 for 5..9; one carry pulse; wrap_cnt=1.
- Glitch rejection: in TRACK at 3, drive 10'h040 for 1 cycle, then back to 10'h008 -> no change, no err (STABLE_CYC=2).
- Skip: at 3, drive 10'h020 (5) -> err_seq pulse, valid=0, bcd_q=3. Then 10'h040 -> valid=1, bcd_q=6, no carry.
- Illegal: drive 10'h003 -> err_code pulse, FAULT. Drive 10'h000 -> second err_code pulse.
- Async reset mid-run: at bcd_q=7, wrap_cnt=2, pulse mr_n low between edges -> all outputs 0 immediately. A held code re-accepted after STABLE_CYC edges enters TRACK with no err.
